// File: rtl/rs_pkg.sv
// Shared types and default sizing for the age-ordered reservation station.
package rs_pkg;

  localparam int RS_DEPTH     = 8;
  localparam int RS_CDB_WIDTH = 2;
  localparam int RS_PRF_IDX   = 6;
  localparam int RS_PAYLOAD_W = 64;
  localparam int RS_IDX       = $clog2(RS_DEPTH);

  // One station slot at the default sizing; the top rebuilds the same
  // layout from its own parameters so other sizings stay legal.
  typedef struct packed {
    logic                    busy;
    logic [RS_PRF_IDX-1:0]   rs1_phy;
    logic                    rs1_rdy;
    logic [RS_PRF_IDX-1:0]   rs2_phy;
    logic                    rs2_rdy;
    logic [RS_PAYLOAD_W-1:0] payload;
  } rs_entry_t;

  // One CDB broadcast lane.
  typedef struct packed {
    logic                  valid;
    logic [RS_PRF_IDX-1:0] rd_phy;
  } cdb_wakeup_t;

endpackage

// File: rtl/age_rs_if.sv
// Dispatch, CDB and issue signals of the reservation station.
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high; in_ready depends only on registered state, and iss_valid may
// drop without a transfer only during a flush.
interface age_rs_if
  import rs_pkg::*;
#(
  parameter int DEPTH     = RS_DEPTH,
  parameter int CDB_WIDTH = RS_CDB_WIDTH,
  parameter int PRF_IDX   = RS_PRF_IDX,
  parameter int PAYLOAD_W = RS_PAYLOAD_W
);
  localparam int OCC_W = $clog2(DEPTH) + 1;

  logic                         in_valid;
  logic                         in_ready;
  logic [PRF_IDX-1:0]           in_rs1_phy;
  logic [PRF_IDX-1:0]           in_rs2_phy;
  logic                         in_rs1_valid;
  logic                         in_rs2_valid;
  logic [PAYLOAD_W-1:0]         in_payload;
  logic [CDB_WIDTH-1:0]         cdb_valid;
  logic [CDB_WIDTH*PRF_IDX-1:0] cdb_rd_phy;
  logic                         iss_valid;
  logic                         iss_ready;
  logic [PRF_IDX-1:0]           iss_rs1_phy;
  logic [PRF_IDX-1:0]           iss_rs2_phy;
  logic [PAYLOAD_W-1:0]         iss_payload;
  logic [OCC_W-1:0]             occupancy;

  // Dispatch / CDB / functional-unit side.
  modport master (
    output in_valid, in_rs1_phy, in_rs2_phy, in_rs1_valid, in_rs2_valid,
           in_payload, cdb_valid, cdb_rd_phy, iss_ready,
    input  in_ready, iss_valid, iss_rs1_phy, iss_rs2_phy, iss_payload,
           occupancy
  );

  // Reservation station side.
  modport slave (
    input  in_valid, in_rs1_phy, in_rs2_phy, in_rs1_valid, in_rs2_valid,
           in_payload, cdb_valid, cdb_rd_phy, iss_ready,
    output in_ready, iss_valid, iss_rs1_phy, iss_rs2_phy, iss_payload,
           occupancy
  );

endinterface

// File: rtl/rs_age_matrix.sv
// Age matrix: row i bit j set means entry j is older than entry i.
// Picks the oldest requester as a one-hot grant.
module rs_age_matrix #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush_i,
  input  logic                     alloc_i,
  input  logic [$clog2(DEPTH)-1:0] alloc_idx_i,
  input  logic [DEPTH-1:0]         busy_i,
  input  logic [DEPTH-1:0]         req_i,
  output logic [DEPTH-1:0]         grant_o
);

  logic [DEPTH-1:0] row_q [DEPTH];
  logic [DEPTH-1:0] row_d [DEPTH];

  // Allocation: the new entry is younger than every busy one, and no
  // existing row may still claim the reused slot as older (column clear).
  always_comb begin
    for (int i = 0; i < DEPTH; i++) row_d[i] = row_q[i];
    if (flush_i) begin
      for (int i = 0; i < DEPTH; i++) row_d[i] = '0;
    end else if (alloc_i) begin
      for (int j = 0; j < DEPTH; j++) row_d[j][alloc_idx_i] = 1'b0;
      row_d[alloc_idx_i] = busy_i;
      row_d[alloc_idx_i][alloc_idx_i] = 1'b0;
    end
  end

  // Matrix state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) row_q[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) row_q[i] <= row_d[i];
    end
  end

  // A requester wins when no older entry is also requesting.
  always_comb begin
    grant_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      grant_o[i] = req_i[i] && ((req_i & row_q[i]) == '0);
    end
  end

endmodule

// File: rtl/age_rs.sv
// Oldest-first reservation station with CDB wakeup, same-cycle bypass,
// flush and occupancy count.
module age_rs
  import rs_pkg::*;
#(
  parameter int DEPTH     = RS_DEPTH,
  parameter int CDB_WIDTH = RS_CDB_WIDTH,
  parameter int PRF_IDX   = RS_PRF_IDX,
  parameter int PAYLOAD_W = RS_PAYLOAD_W
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   flush,
  age_rs_if.slave bus
);

  localparam int IDX   = $clog2(DEPTH);
  localparam int OCC_W = IDX + 1;

  typedef struct packed {
    logic                 busy;
    logic [PRF_IDX-1:0]   rs1_phy;
    logic                 rs1_rdy;
    logic [PRF_IDX-1:0]   rs2_phy;
    logic                 rs2_rdy;
    logic [PAYLOAD_W-1:0] payload;
  } entry_t;

  entry_t             ent_q [DEPTH];
  entry_t             ent_d [DEPTH];
  logic [OCC_W-1:0]   occ_q, occ_d;

  logic [DEPTH-1:0]   busy_vec, ready_vec, grant;
  logic [DEPTH-1:0]   hit1, hit2;
  logic               in_hit1, in_hit2;
  logic [IDX-1:0]     free_idx;
  logic               in_ready, push, iss_valid, issue;
  logic [PRF_IDX-1:0]   sel_rs1, sel_rs2;
  logic [PAYLOAD_W-1:0] sel_payload;

  // True when any valid CDB lane broadcasts this physical register.
  function automatic logic cdb_hit(
    input logic [CDB_WIDTH-1:0]         v,
    input logic [CDB_WIDTH*PRF_IDX-1:0] rd,
    input logic [PRF_IDX-1:0]           phy
  );
    logic hit;
    hit = 1'b0;
    for (int l = 0; l < CDB_WIDTH; l++) begin
      if (v[l] && (rd[l*PRF_IDX +: PRF_IDX] == phy)) hit = 1'b1;
    end
    return hit;
  endfunction

  // CDB matches for every entry and for the incoming uop; an entry is
  // ready when each source is already ready or woken this very cycle.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      busy_vec[i]  = ent_q[i].busy;
      hit1[i]      = cdb_hit(bus.cdb_valid, bus.cdb_rd_phy, ent_q[i].rs1_phy);
      hit2[i]      = cdb_hit(bus.cdb_valid, bus.cdb_rd_phy, ent_q[i].rs2_phy);
      ready_vec[i] = ent_q[i].busy && (ent_q[i].rs1_rdy || hit1[i])
                                   && (ent_q[i].rs2_rdy || hit2[i]);
    end
    in_hit1 = cdb_hit(bus.cdb_valid, bus.cdb_rd_phy, bus.in_rs1_phy);
    in_hit2 = cdb_hit(bus.cdb_valid, bus.cdb_rd_phy, bus.in_rs2_phy);
  end

  // Lowest-index free slot receives the next push.
  always_comb begin
    free_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!ent_q[i].busy) free_idx = IDX'(i);
    end
  end

  assign in_ready  = (occ_q < OCC_W'(DEPTH));
  assign push      = bus.in_valid && in_ready && !flush;
  assign iss_valid = (|ready_vec) && !flush;
  assign issue     = iss_valid && bus.iss_ready;

  rs_age_matrix #(.DEPTH(DEPTH)) u_age (
    .clk        (clk),
    .rst        (rst),
    .flush_i    (flush),
    .alloc_i    (push),
    .alloc_idx_i(free_idx),
    .busy_i     (busy_vec),
    .req_i      (ready_vec),
    .grant_o    (grant)
  );

  // Read mux for the granted (one-hot) entry.
  always_comb begin
    sel_rs1     = '0;
    sel_rs2     = '0;
    sel_payload = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (grant[i]) begin
        sel_rs1     = ent_q[i].rs1_phy;
        sel_rs2     = ent_q[i].rs2_phy;
        sel_payload = ent_q[i].payload;
      end
    end
  end

  // Entry next state: wakeup, issue clear, push write, flush clear.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ent_d[i] = ent_q[i];
      if (ent_q[i].busy) begin
        ent_d[i].rs1_rdy = ent_q[i].rs1_rdy || hit1[i];
        ent_d[i].rs2_rdy = ent_q[i].rs2_rdy || hit2[i];
      end
      if (issue && grant[i]) ent_d[i].busy = 1'b0;
      if (push && (free_idx == IDX'(i))) begin
        ent_d[i].busy    = 1'b1;
        ent_d[i].rs1_phy = bus.in_rs1_phy;
        ent_d[i].rs1_rdy = bus.in_rs1_valid || in_hit1;
        ent_d[i].rs2_phy = bus.in_rs2_phy;
        ent_d[i].rs2_rdy = bus.in_rs2_valid || in_hit2;
        ent_d[i].payload = bus.in_payload;
      end
      if (flush) ent_d[i].busy = 1'b0;
    end
  end

  // Occupancy tracks push minus issue; flush empties the station.
  always_comb begin
    if (flush) occ_d = '0;
    else       occ_d = occ_q + OCC_W'(push) - OCC_W'(issue);
  end

  // Entry array and occupancy registers; rst wins over flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
      occ_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
      occ_q <= occ_d;
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.iss_valid   = iss_valid;
  assign bus.iss_rs1_phy = sel_rs1;
  assign bus.iss_rs2_phy = sel_rs2;
  assign bus.iss_payload = sel_payload;
  assign bus.occupancy   = occ_q;

endmodule
